// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative write-back L1 cache: sequences the
// datapath arrays and the pmem handshake. Optional counters: CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  input  logic [1:0]        cache_hit,
  input  logic              write_back,
  input  logic              way,
  input  logic              way_reg,
  output logic [1:0]        load_dirty,
  output logic [1:0]        load_valid,
  output logic [1:0]        load_tag,
  output logic              set_dirty,
  output logic              set_valid,
  output logic              set_lru,
  output logic              load_lru,
  output logic              way_sel,
  output logic              addr_sel,
  output logic [1:0]        write_sel,
  output logic              load_way_reg,
  output logic [1:0]        read_data_array,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt,
  output logic [PERF_W-1:0] wb_cnt
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, FILL, REREAD} state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Strobes are gated by rst_n so every output is 0 while reset is held,
  // including the IDLE read-enable that would follow a pending request.
  always_comb begin
    state_d         = state_q;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    load_dirty      = 2'b00;
    load_valid      = 2'b00;
    load_tag        = 2'b00;
    set_dirty       = 1'b0;
    set_valid       = 1'b0;
    set_lru         = 1'b0;
    load_lru        = 1'b0;
    way_sel         = 1'b0;
    addr_sel        = 1'b0;
    write_sel       = 2'b00;
    load_way_reg    = 1'b0;
    read_data_array = 2'b00;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (mem_read | mem_write) begin
            read_data_array = 2'b11;
            state_d         = CHECK;
          end
        end
        CHECK: begin
          if (|cache_hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            set_lru  = ~way;
            // Write wins when both request lines are (illegally) high.
            if (mem_write) begin
              way_sel         = way;
              write_sel       = 2'b10;
              load_dirty[way] = 1'b1;
              set_dirty       = 1'b1;
            end
            state_d = IDLE;
          end else begin
            load_way_reg = 1'b1;
            state_d      = write_back ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          way_sel    = way_reg;
          addr_sel   = 1'b1;
          if (pmem_resp) begin
            load_dirty[way_reg] = 1'b1;
            state_d             = FILL;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = way_reg;
          if (pmem_resp) begin
            write_sel           = 2'b01;
            load_tag[way_reg]   = 1'b1;
            load_valid[way_reg] = 1'b1;
            set_valid           = 1'b1;
            load_dirty[way_reg] = 1'b1;
            state_d             = REREAD;
          end
        end
        REREAD: begin
          read_data_array = 2'b11;
          state_d         = CHECK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [PERF_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [PERF_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [PERF_W-1:0] wb_cnt_q, wb_cnt_d;
  logic              refill_q, refill_d;

  // refill_q marks the CHECK that completes a miss so it is not counted as a hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    refill_d   = (state_q == REREAD);
    if (state_q == CHECK && (|cache_hit) && !refill_q && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + PERF_W'(1);
    if (state_q == CHECK && !(|cache_hit) && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + PERF_W'(1);
    if (state_q == WRITEBACK && pmem_resp && wb_cnt_q != '1)
      wb_cnt_d = wb_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
      refill_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      refill_q   <= refill_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control with a behavioural 2-way datapath and a
// fixed-latency pmem responder; a monitor checks each mem_resp against the queue.
module tb_cache_control;
  localparam int PW  = 32;
  localparam int LAT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, mem_resp;
  logic pmem_read, pmem_write, pmem_resp = 1'b0;
  logic [1:0] cache_hit;
  logic write_back, way, way_reg;
  logic [1:0] load_dirty, load_valid, load_tag, write_sel, read_data_array;
  logic set_dirty, set_valid, set_lru, load_lru, way_sel, addr_sel, load_way_reg;
  logic [PW-1:0] hit_cnt, miss_cnt, wb_cnt;
  logic [31:0] addr = '0;

  cache_control #(.PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .cache_hit(cache_hit), .write_back(write_back),
    .way(way), .way_reg(way_reg), .load_dirty(load_dirty), .load_valid(load_valid),
    .load_tag(load_tag), .set_dirty(set_dirty), .set_valid(set_valid),
    .set_lru(set_lru), .load_lru(load_lru), .way_sel(way_sel), .addr_sel(addr_sel),
    .write_sel(write_sel), .load_way_reg(load_way_reg),
    .read_data_array(read_data_array), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath model: set = addr[10:8], tag = addr[31:11]
  logic [20:0] tag_a   [2][8];
  logic        valid_a [2][8];
  logic        dirty_a [2][8];
  logic        lru_a   [8];
  logic        dp_clr = 1'b1;
  logic        wreg = 1'b0;
  logic [2:0]  set_i;
  logic [20:0] tag_i;

  assign set_i   = addr[10:8];
  assign tag_i   = addr[31:11];
  assign way_reg = wreg;

  always_comb begin
    cache_hit[0] = valid_a[0][set_i] && (tag_a[0][set_i] == tag_i);
    cache_hit[1] = valid_a[1][set_i] && (tag_a[1][set_i] == tag_i);
    way          = cache_hit[1] ? 1'b1 : (cache_hit[0] ? 1'b0 : lru_a[set_i]);
    write_back   = valid_a[lru_a[set_i]][set_i] && dirty_a[lru_a[set_i]][set_i];
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 8; s++) begin
          tag_a[w][s] <= '0; valid_a[w][s] <= 1'b0; dirty_a[w][s] <= 1'b0;
        end
      for (int s = 0; s < 8; s++) lru_a[s] <= 1'b0;
    end else begin
      if (load_way_reg) wreg <= way;
      for (int w = 0; w < 2; w++) begin
        if (load_tag[w])   tag_a[w][set_i]   <= tag_i;
        if (load_valid[w]) valid_a[w][set_i] <= set_valid;
        if (load_dirty[w]) dirty_a[w][set_i] <= set_dirty;
      end
      if (load_lru) lru_a[set_i] <= set_lru;
    end
  end

  // ---------------- pmem responder: resp in the LAT-th cycle of a request
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (!rst_n) cnt = 0;
      else if (pmem_read | pmem_write) begin
        cnt++;
        if (cnt == LAT) begin pmem_resp = 1'b1; cnt = 0; end
      end else cnt = 0;
    end
  end

  // ---------------- scoreboard
  typedef struct {
    int         start;
    int         lat;
    int         rd;
    int         wr;
    logic [1:0] ld_tag;
    logic [1:0] wsel;
    logic [1:0] ld_dirty;
    logic       sdirty;
    logic       slru;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int mon_rd = 0, mon_wr = 0, mon_asel = 0;
  logic [1:0] mon_tag = 2'b00;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint pc(input longint v);
`ifdef CACHE_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (pmem_read) mon_rd++;
      if (pmem_write) begin mon_wr++; if (addr_sel) mon_asel++; end
      if (pmem_resp && pmem_read) mon_tag = load_tag;
      if (mem_resp) begin
        if (exp_q.size() == 0) chk("unexpected_mem_resp", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency",    cyc - e.start, e.lat);
          chk("fill_cyc",   mon_rd,   e.rd);
          chk("wb_cyc",     mon_wr,   e.wr);
          chk("wb_addrsel", mon_asel, e.wr);
          chk("fill_ldtag", mon_tag,  e.ld_tag);
          chk("write_sel",  write_sel,  e.wsel);
          chk("load_dirty", load_dirty, e.ld_dirty);
          chk("set_dirty",  set_dirty,  e.sdirty);
          chk("set_lru",    set_lru,    e.slru);
          chk("load_lru",   load_lru,   1);
        end
        mon_rd = 0; mon_wr = 0; mon_asel = 0; mon_tag = 2'b00;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic rd, input logic wr,
                       input int lat, input int nrd, input int nwr,
                       input logic [1:0] ltag, input logic [1:0] wsel,
                       input logic [1:0] ldd, input logic sd, input logic sl);
    exp_t e;
    bit got;
    @(posedge clk); #1;
    e.start = cyc; e.lat = lat; e.rd = nrd; e.wr = nwr; e.ld_tag = ltag;
    e.wsel = wsel; e.ld_dirty = ldd; e.sdirty = sd; e.slru = sl;
    exp_q.push_back(e);
    addr = a; mem_read = rd; mem_write = wr;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (mem_resp) got = 1;
    end
    if (!got) begin
      chk("resp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #12;
    chk("rst_mem_resp",  mem_resp, 0);
    chk("rst_pmem_rw",   {pmem_read, pmem_write}, 0);
    chk("rst_rd_array",  read_data_array, 0);
    chk("rst_miss_cnt",  miss_cnt, 0);
    @(posedge clk); #1 dp_clr = 1'b0;
    #2 rst_n = 1'b1;

    // clean miss set 0, way 0
    issue(32'h40, 1, 0, LAT + 3, LAT, 0, 2'b01, 2'b00, 2'b00, 0, 1);
    chk("miss_cnt_1", miss_cnt, pc(1));
    chk("hit_cnt_0",  hit_cnt,  pc(0));
    // read hit
    issue(32'h40, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    chk("hit_cnt_1", hit_cnt, pc(1));
    // write hit
    issue(32'h40, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b01, 1, 1);
    chk("dirty_w0s0", dirty_a[0][0], 1);
    // set 2: write-miss fill way 0 (dirty), read-miss fill way 1, third tag evicts dirty way 0
    issue(32'h200,  0, 1, LAT + 3, LAT, 0, 2'b01, 2'b10, 2'b01, 1, 1);
    issue(32'hA00,  1, 0, LAT + 3, LAT, 0, 2'b10, 2'b00, 2'b00, 0, 0);
    issue(32'h1200, 1, 0, 2*LAT + 3, LAT, LAT, 2'b01, 2'b00, 2'b00, 0, 1);
    chk("wb_cnt_1",      wb_cnt,   pc(1));
    chk("miss_cnt_4",    miss_cnt, pc(4));
    chk("hit_cnt_2",     hit_cnt,  pc(2));
    chk("victim_clean",  dirty_a[0][2], 0);

    // reset during FILL of set 0 way 1
    @(posedge clk); #1;
    addr = 32'h3000; mem_read = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (pmem_read) seen = 1;
      end
      chk("fill_reached", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rstfill_pmem_read", pmem_read, 0);
    chk("rstfill_mem_resp",  mem_resp, 0);
    chk("rstfill_rd_array",  read_data_array, 0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    mon_rd = 0; mon_wr = 0; mon_asel = 0; mon_tag = 2'b00;
    chk("rstfill_miss_cnt", miss_cnt, 0);
    issue(32'h3000, 1, 0, LAT + 3, LAT, 0, 2'b10, 2'b00, 2'b00, 0, 0);
    chk("after_rst_miss", miss_cnt, pc(1));

    // read+write together on a hit: write path wins
    issue(32'h40, 1, 1, 1, 0, 0, 2'b00, 2'b10, 2'b01, 1, 1);
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way set-associative, write-back/write-allocate L1 cache. It sequences the cache datapath's data, tag, valid, dirty and LRU arrays, and the physical-memory handshake. It sits between the CPU-side memory port and the cacheline adaptor/arbiter. The datapath's hit, dirty-victim and way signals are inputs; every datapath load/select strobe is an output.

## Interface
- `PERF_W`, 32, width of the performance counters (see Configuration).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`, `mem_write`  in  1 each  CPU request; held with its address/data until `mem_resp`.
- `mem_resp`  out  1  one-cycle completion pulse to the CPU.
- `pmem_read`, `pmem_write`  out  1 each  physical-memory line request.
- `pmem_resp`  in  1  physical-memory completion pulse.
- `cache_hit`  in  2  per-way hit from the datapath.
- `write_back`  in  1  LRU victim of the indexed set is dirty.
- `way`  in  1  hit way, or LRU way on a miss.
- `way_reg`  in  1  latched victim way.
- `load_dirty`, `load_valid`, `load_tag`  out  2 each  per-way load strobes.
- `set_dirty`, `set_valid`, `set_lru`, `load_lru`  out  1 each  array write values/strobe.
- `way_sel`  out  1  way driving pmem_wdata/pmem_address and receiving writes.
- `addr_sel`  out  1  0 = CPU line address to pmem, 1 = victim tag address.
- `write_sel`  out  2  00 no write, 01 refill from pmem_rdata, 10 CPU write with byte enables.
- `load_way_reg`  out  1  capture `way` into `way_reg`.
- `read_data_array`  out  2  per-way data-array read enable.
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  PERF_W each  performance counters.

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL, REREAD.
- **IDLE**
  - If `mem_read|mem_write`: `read_data_array=11`, go to CHECK.
  - Otherwise stay. All strobes 0.
- **CHECK, hit** (`|cache_hit`):
  - `mem_resp=1`, `load_lru=1`, `set_lru=~way` (LRU bit names the way to evict next).
  - Write hit additionally: `way_sel=way`, `write_sel=10`, `load_dirty[way]=1`, `set_dirty=1`.
  - Go to IDLE.
- **CHECK, miss**:
  - `load_way_reg=1`.
  - If `write_back`, go to WRITEBACK; else go to FILL.
- **WRITEBACK**
  - `pmem_write=1`, `way_sel=way_reg`, `addr_sel=1`.
  - On `pmem_resp`: `load_dirty[way_reg]=1`, `set_dirty=0`, go to FILL.
- **FILL**
  - `pmem_read=1`, `way_sel=way_reg`, `addr_sel=0`.
  - On `pmem_resp`: `write_sel=01`, `load_tag[way_reg]`, `load_valid[way_reg]`, `set_valid=1`, `load_dirty[way_reg]=1`, `set_dirty=0`, go to REREAD.
- **REREAD**
  - `read_data_array=11`, go to CHECK (now guaranteed hit).
- Both `mem_read` and `mem_write` high is illegal; the write path takes priority.
- Only the single hot `load_*[w]` bit for the selected way may be set.

## Timing
- Reset (async, on `rst_n` low): state=IDLE; every output 0; counters 0. `pmem_read/pmem_write` drop immediately, even mid-transfer.
- Read/write hit: request seen in IDLE at cycle 0, `mem_resp` in cycle 1. Latency 2 edges.
- Clean miss: 1 (IDLE) + 1 (CHECK) + N_fill + 1 (REREAD) + 1 (CHECK, resp).
- Dirty miss adds N_wb.
- `pmem_read/pmem_write` held continuously until the cycle `pmem_resp` is sampled high. They deassert the following cycle.
- `mem_resp` is exactly one cycle. A request still high in the next IDLE cycle is a new request.
- `pmem_resp` outside WRITEBACK/FILL is ignored.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - `hit_cnt` increments on each CHECK hit that is not the post-REREAD completion.
  - `miss_cnt` increments on each CHECK miss.
  - `wb_cnt` increments on each WRITEBACK `pmem_resp`.
  - Counters saturate at all-ones.
- Not defined: counters are not instantiated; the three outputs are tied to 0.

## Test plan
- Reset, then read to empty set 0 (addr 0x0000_0040) -> `pmem_read` from cycle 2; after `pmem_resp` `load_tag=01`, `set_valid=1`; `mem_resp` 2 cycles after `pmem_resp`; `miss_cnt=1`.
- Repeat read of 0x40 -> `mem_resp` in cycle 1, `pmem_read` never asserted, `set_lru=1`, `hit_cnt=1`.
- Write hit of 0x40 with byte enable 0x0000_000F -> `write_sel=10`, `load_dirty=01`, `set_dirty=1`, `mem_resp` cycle 1.
- Fill way 1 of set 2, then access a third tag in set 2 with the victim dirty -> `pmem_write` with `addr_sel=1` until `pmem_resp`, then `pmem_read`; `wb_cnt=1`; victim dirty cleared.
- Drop `rst_n` during FILL with `pmem_read` high -> `pmem_read=0` in the same cycle, state IDLE, no `mem_resp`; the next read completes normally.
- Assert `mem_read` and `mem_write` together on a hit -> write path taken (`write_sel=10`), single `mem_resp`.
